// File: rtl/datamover_axi_pkg.sv
// Shared AXI response/state types and helpers for the HP0 memory responder.
package datamover_axi_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axi_resp_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  typedef struct packed {
    logic [63:0] data;
    axi_resp_e   resp;
    logic        last;
  } rbeat_t;

  // Encoding order already ranks severity: DECERR > SLVERR > OKAY.
  function automatic axi_resp_e resp_max(input axi_resp_e a, input axi_resp_e b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/axi_hp_ram_dp.sv
// Simple dual-port RAM: byte-lane write port, registered read-first read port.
module axi_hp_ram_dp #(
  parameter int DEPTH     = 4096,
  parameter int NUM_LANES = 8
) (
  input  logic                            i_clk,
  input  logic                            i_we,
  input  logic [$clog2(DEPTH)-1:0]        i_waddr,
  input  logic [NUM_LANES-1:0]            i_wbe,
  input  logic [NUM_LANES-1:0][7:0]       i_wdata,
  input  logic                            i_re,
  input  logic [$clog2(DEPTH)-1:0]        i_raddr,
  output logic [NUM_LANES-1:0][7:0]       o_rdata
);
  logic [NUM_LANES-1:0][7:0] r_mem [DEPTH];

  // Nonblocking read and write in one process gives read-first on collisions.
  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
    for (int b = 0; b < NUM_LANES; b++)
      if (i_we && i_wbe[b]) r_mem[i_waddr][b] <= i_wdata[b];
  end
endmodule

// File: rtl/axi_hp_mem_responder.sv
// AXI4 slave serving INCR bursts from on-chip dual-port RAM; independent read and write channels.
module axi_hp_mem_responder
  import datamover_axi_pkg::*;
#(
  parameter int                ID_W        = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk_dma,
  input  logic              rst_dma,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [63:0]       s_wdata,
  input  logic [7:0]        s_wstrb,
  input  logic              s_wlast,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [63:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast
);
  localparam int                AW      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  // Holds both address channels off for one cycle after reset release.
  logic r_live;
  always_ff @(posedge clk_dma or posedge rst_dma)
    if (rst_dma) r_live <= 1'b0;
    else         r_live <= 1'b1;

  // ---------------- write channel ----------------
  wr_state_e         r_wst, w_wst_nxt;
  logic [ID_W-1:0]   r_wid;
  logic [ADDR_W-1:0] r_wword, w_wbeat;
  logic [7:0]        r_wlen, r_wcnt;
  logic              r_wbad, w_win, w_wlast, w_whs, w_awhs, w_we;
  axi_resp_e         r_bresp, w_wresp;

  assign w_awhs  = s_awvalid & s_awready;
  assign w_whs   = s_wvalid & s_wready;
  assign w_wbeat = r_wword + ADDR_W'(r_wcnt);
  assign w_win   = w_wbeat < DEPTH_L;
  assign w_wlast = (r_wcnt == r_wlen);
  assign w_we    = w_whs & ~r_wbad & w_win;
  assign s_bid   = r_wid;
  assign s_bresp = r_bresp;

  always_comb begin
    w_wresp = OKAY;
    if (r_wbad)      w_wresp = SLVERR;
    else if (!w_win) w_wresp = DECERR;
    if (s_wlast != w_wlast) w_wresp = resp_max(w_wresp, SLVERR);
  end

  always_comb begin
    w_wst_nxt = r_wst;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (r_wst)
      W_IDLE: begin
        s_awready = r_live;
        if (s_awvalid && r_live) w_wst_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (w_whs && w_wlast) w_wst_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_wst_nxt = W_IDLE;
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) begin
      r_wst   <= W_IDLE;
      r_wid   <= '0;
      r_wword <= '0;
      r_wlen  <= '0;
      r_wcnt  <= '0;
      r_wbad  <= 1'b0;
      r_bresp <= OKAY;
    end else begin
      r_wst <= w_wst_nxt;
      if (w_awhs) begin
        r_wid   <= s_awid;
        r_wword <= (s_awaddr - BASE_ADDR) >> 3;
        r_wlen  <= s_awlen;
        r_wcnt  <= '0;
        r_wbad  <= (s_awsize != SIZE_8B) || (s_awburst != BURST_INCR);
        r_bresp <= OKAY;
      end
      if (w_whs) begin
        r_wcnt  <= r_wcnt + 8'd1;
        r_bresp <= resp_max(r_bresp, w_wresp);
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_e         r_rst;
  logic [ID_W-1:0]   r_rid;
  logic [ADDR_W-1:0] r_rword, w_rbeat;
  logic [7:0]        r_rlen;
  logic [8:0]        r_icnt;
  logic              r_rbad, w_arhs, w_issue, w_re, w_pop;
  axi_resp_e         w_iresp, r_rd_resp;
  logic              r_rd_vld, r_rd_last;
  logic [63:0]       w_ram_q;
  rbeat_t            r_q [2];
  rbeat_t            w_push;
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;

  assign w_arhs    = s_arvalid & s_arready;
  assign s_arready = r_live & (r_rst == R_IDLE);
  assign w_rbeat   = r_rword + ADDR_W'(r_icnt);
  assign w_pop     = s_rvalid & s_rready;

  // Issue only if the beat is guaranteed a skid slot when it leaves the RAM pipe.
  assign w_issue = (r_rst == R_DATA) && (r_icnt <= {1'b0, r_rlen}) &&
                   (({1'b0, r_cnt} + {2'b0, r_rd_vld}) <= (3'd1 + {2'b0, w_pop}));

  always_comb begin
    w_iresp = OKAY;
    if (r_rbad)                 w_iresp = SLVERR;
    else if (w_rbeat >= DEPTH_L) w_iresp = DECERR;
  end
  assign w_re = w_issue & (w_iresp == OKAY);

  always_comb begin
    w_push.data = (r_rd_resp == OKAY) ? w_ram_q : '0;
    w_push.resp = r_rd_resp;
    w_push.last = r_rd_last;
  end

  assign s_rvalid = (r_cnt != 2'd0);
  assign s_rdata  = r_q[r_rp].data;
  assign s_rresp  = r_q[r_rp].resp;
  assign s_rlast  = r_q[r_rp].last;
  assign s_rid    = r_rid;

  always_ff @(posedge clk_dma or posedge rst_dma) begin
    if (rst_dma) begin
      r_rst     <= R_IDLE;
      r_rid     <= '0;
      r_rword   <= '0;
      r_rlen    <= '0;
      r_icnt    <= '0;
      r_rbad    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_resp <= OKAY;
      r_rd_last <= 1'b0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < 2; i++) r_q[i] <= '0;
    end else begin
      if (w_arhs) begin
        r_rst   <= R_DATA;
        r_rid   <= s_arid;
        r_rword <= (s_araddr - BASE_ADDR) >> 3;
        r_rlen  <= s_arlen;
        r_icnt  <= '0;
        r_rbad  <= (s_arsize != SIZE_8B) || (s_arburst != BURST_INCR);
      end else if (w_pop && s_rlast) begin
        r_rst <= R_IDLE;
      end
      if (w_issue) r_icnt <= r_icnt + 9'd1;
      r_rd_vld  <= w_issue;
      r_rd_resp <= w_iresp;
      r_rd_last <= (r_icnt[7:0] == r_rlen);
      if (r_rd_vld) begin
        r_q[r_wp] <= w_push;
        r_wp      <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  axi_hp_ram_dp #(.DEPTH(DEPTH_WORDS), .NUM_LANES(8)) u_ram (
    .i_clk   (clk_dma),
    .i_we    (w_we),
    .i_waddr (w_wbeat[AW-1:0]),
    .i_wbe   (s_wstrb),
    .i_wdata (s_wdata),
    .i_re    (w_re),
    .i_raddr (w_rbeat[AW-1:0]),
    .o_rdata (w_ram_q)
  );
endmodule
